// File: rtl/montgomery_domain_entry_pkg.sv
// Shared widths and FSM state codes for the Montgomery-domain entry block.
package montgomery_domain_entry_pkg;

  localparam int BITS     = 8;
  localparam int LOG_BITS = 3;

  typedef enum logic [1:0] {
    CONV_IDLE   = 2'd0,
    CONV_RUN    = 2'd1,
    CONV_FINISH = 2'd2
  } conv_state_e;

endpackage

// File: rtl/montgomery_domain_entry_mod_double.sv
// Combinational modular doubling: y = 2x mod N, valid while x < N.
module montgomery_domain_entry_mod_double
  import montgomery_domain_entry_pkg::*;
#(
  parameter int WIDTH = BITS
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH:0] dbl;
  logic [WIDTH:0] dbl_sub;

  // The extra bit keeps the carry out of 2x; since x < N, one subtract suffices.
  assign dbl     = {x, 1'b0};
  assign dbl_sub = dbl - {1'b0, n};
  assign y       = (dbl >= {1'b0, n}) ? dbl_sub[WIDTH-1:0] : dbl[WIDTH-1:0];

endmodule

// File: rtl/montgomery_domain_entry.sv
// Maps a plain base into the Montgomery domain (base*R mod N, R mod N) by WIDTH modular doublings.
// Optional MONT_NPRIME_CALC_EN adds an N_prime = -N^-1 mod R Hensel-lift datapath in the same cycles.
module montgomery_domain_entry
  import montgomery_domain_entry_pkg::*;
#(
  parameter int WIDTH = BITS,
  parameter int CNT_W = LOG_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] N,
  output logic             finish,
  output logic             err,
  output logic [WIDTH-1:0] base_mont,
  output logic [WIDTH-1:0] one_mont
`ifdef MONT_NPRIME_CALC_EN
  ,
  output logic [WIDTH-1:0] N_prime
`endif
);

  conv_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic             bad_q, bad_d;
  logic             finish_q, finish_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] base_mont_q, base_mont_d;
  logic [WIDTH-1:0] one_mont_q, one_mont_d;
  logic [WIDTH-1:0] x_dbl, r_dbl;
`ifdef MONT_NPRIME_CALC_EN
  logic [WIDTH-1:0] t_q, t_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] n_prime_q, n_prime_d;
  logic [CNT_W-1:0] bit_idx;

  // Counter runs WIDTH-1 down to 0 while the lifted bit runs 0 up to WIDTH-1.
  assign bit_idx = CNT_W'(WIDTH - 1) - count_q;
`endif

  montgomery_domain_entry_mod_double #(.WIDTH(WIDTH)) u_dbl_x (
    .x (x_q),
    .n (n_q),
    .y (x_dbl)
  );

  montgomery_domain_entry_mod_double #(.WIDTH(WIDTH)) u_dbl_r (
    .x (r_q),
    .n (n_q),
    .y (r_dbl)
  );

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned and infers a latch.
    state_d     = state_q;
    count_d     = count_q;
    x_d         = x_q;
    r_d         = r_q;
    n_d         = n_q;
    bad_d       = bad_q;
    finish_d    = 1'b0;
    err_d       = err_q;
    base_mont_d = base_mont_q;
    one_mont_d  = one_mont_q;
`ifdef MONT_NPRIME_CALC_EN
    t_d         = t_q;
    y_d         = y_q;
    n_prime_d   = n_prime_q;
`endif

    unique case (state_q)
      CONV_IDLE: begin
        if (start) begin
          n_d     = N;
          x_d     = base;
          // 1 mod N, so that N == 1 also keeps r < N and yields 0.
          r_d     = {{(WIDTH-1){1'b0}}, (N != {{(WIDTH-1){1'b0}}, 1'b1})};
          count_d = CNT_W'(WIDTH - 1);
`ifdef MONT_NPRIME_CALC_EN
          t_d     = {{(WIDTH-1){1'b0}}, 1'b1};
          y_d     = '0;
`endif
          if (!N[0] || (base >= N)) begin
            bad_d   = 1'b1;
            state_d = CONV_FINISH;
          end else begin
            bad_d   = 1'b0;
            state_d = CONV_RUN;
          end
        end
      end

      CONV_RUN: begin
        x_d = x_dbl;
        r_d = r_dbl;
`ifdef MONT_NPRIME_CALC_EN
        if (t_q[bit_idx]) begin
          t_d          = t_q + (n_q << bit_idx);
          y_d[bit_idx] = 1'b1;
        end
`endif
        if (count_q == '0) begin
          state_d = CONV_FINISH;
        end else begin
          count_d = count_q - 1'b1;
        end
      end

      CONV_FINISH: begin
        finish_d    = 1'b1;
        err_d       = bad_q;
        base_mont_d = bad_q ? '0 : x_q;
        one_mont_d  = bad_q ? '0 : r_q;
`ifdef MONT_NPRIME_CALC_EN
        n_prime_d   = bad_q ? '0 : y_q;
`endif
        state_d     = CONV_IDLE;
      end

      default: state_d = CONV_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CONV_IDLE;
      count_q     <= '0;
      x_q         <= '0;
      r_q         <= '0;
      n_q         <= '0;
      bad_q       <= 1'b0;
      finish_q    <= 1'b0;
      err_q       <= 1'b0;
      base_mont_q <= '0;
      one_mont_q  <= '0;
`ifdef MONT_NPRIME_CALC_EN
      t_q         <= '0;
      y_q         <= '0;
      n_prime_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      x_q         <= x_d;
      r_q         <= r_d;
      n_q         <= n_d;
      bad_q       <= bad_d;
      finish_q    <= finish_d;
      err_q       <= err_d;
      base_mont_q <= base_mont_d;
      one_mont_q  <= one_mont_d;
`ifdef MONT_NPRIME_CALC_EN
      t_q         <= t_d;
      y_q         <= y_d;
      n_prime_q   <= n_prime_d;
`endif
    end
  end

  assign finish    = finish_q;
  assign err       = err_q;
  assign base_mont = base_mont_q;
  assign one_mont  = one_mont_q;
`ifdef MONT_NPRIME_CALC_EN
  assign N_prime   = n_prime_q;
`endif

endmodule

// File: tb/tb_montgomery_domain_entry.sv
// Directed and randomised checks of montgomery_domain_entry at WIDTH=8 (R=256).
module tb_montgomery_domain_entry;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] base_i;
  logic [W-1:0] n_i;
  logic         finish;
  logic         err;
  logic [W-1:0] base_mont;
  logic [W-1:0] one_mont;
`ifdef MONT_NPRIME_CALC_EN
  logic [W-1:0] n_prime;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  montgomery_domain_entry #(.WIDTH(W), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base_i),
    .N         (n_i),
    .finish    (finish),
    .err       (err),
    .base_mont (base_mont),
    .one_mont  (one_mont)
`ifdef MONT_NPRIME_CALC_EN
    ,
    .N_prime   (n_prime)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts a conversion (start sampled at edge 0) and returns the edge index where finish is seen.
  task automatic run_conv(input int n, input int b, output int lat);
    @(negedge clk);
    n_i    = W'(n);
    base_i = W'(b);
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (finish) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic wait_no_finish(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (finish) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    int lat;
    int n, b, fins;

    rst    = 1'b1;
    start  = 1'b0;
    base_i = '0;
    n_i    = '0;
    #12;
    check("rst_finish", finish, 0);
    check("rst_err", err, 0);
    check("rst_base_mont", base_mont, 0);
    check("rst_one_mont", one_mont, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: N=13, base=5
    run_conv(13, 5, lat);
    check("t1_latency", lat, 9);
    check("t1_base_mont", base_mont, 6);
    check("t1_one_mont", one_mont, 9);
    check("t1_err", err, 0);
`ifdef MONT_NPRIME_CALC_EN
    check("t1_n_prime", n_prime, 59);
`endif
    @(posedge clk);
    #1 check("t1_pulse_width", finish, 0);

    // 2: zero base
    run_conv(13, 0, lat);
    check("t2_latency", lat, 9);
    check("t2_base_mont", base_mont, 0);
    check("t2_one_mont", one_mont, 9);
    check("t2_err", err, 0);

    // 3: even modulus, then base == N
    run_conv(12, 5, lat);
    check("t3a_latency", lat, 1);
    check("t3a_err", err, 1);
    check("t3a_base_mont", base_mont, 0);
    check("t3a_one_mont", one_mont, 0);
`ifdef MONT_NPRIME_CALC_EN
    check("t3a_n_prime", n_prime, 0);
`endif
    run_conv(13, 13, lat);
    check("t3b_latency", lat, 1);
    check("t3b_err", err, 1);
    check("t3b_base_mont", base_mont, 0);
    check("t3b_one_mont", one_mont, 0);

    // 4: start re-pulsed (N=11) at edges +3 (RUN) and +9 (FINISH) must be ignored
    @(negedge clk);
    n_i = 8'd13; base_i = 8'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    fins = 0;
    lat  = 0;
    for (int c = 1; c <= 22; c++) begin
      if (c == 3 || c == 9) begin
        n_i = 8'd11; base_i = 8'd3; start = 1'b1;
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (finish) begin
        fins++;
        if (lat == 0) lat = c;
      end
    end
    check("t4_latency", lat, 9);
    check("t4_finish_count", fins, 1);
    check("t4_base_mont", base_mont, 6);
    check("t4_one_mont", one_mont, 9);
    check("t4_err", err, 0);

    // 5: async reset mid-run aborts with no finish
    @(negedge clk);
    n_i = 8'd13; base_i = 8'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_base_mont", base_mont, 0);
    check("t5_rst_one_mont", one_mont, 0);
    check("t5_rst_finish", finish, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_no_finish("t5_no_finish", 12);
    run_conv(255, 254, lat);
    check("t5_latency", lat, 9);
    check("t5_base_mont", base_mont, 254);
    check("t5_one_mont", one_mont, 1);
    check("t5_err", err, 0);

    // N == 1 is valid and yields zeros
    run_conv(1, 0, lat);
    check("n1_latency", lat, 9);
    check("n1_err", err, 0);
    check("n1_base_mont", base_mont, 0);
    check("n1_one_mont", one_mont, 0);

    // 6: random odd N, base < N, against (base*256) % N
    for (int k = 0; k < 1000; k++) begin
      n = 2 * int'($urandom_range(0, 127)) + 1;
      b = int'($urandom_range(0, n - 1));
      run_conv(n, b, lat);
      check("t6_latency", lat, 9);
      check("t6_base_mont", base_mont, (b * 256) % n);
      check("t6_one_mont", one_mont, 256 % n);
`ifdef MONT_NPRIME_CALC_EN
      check("t6_n_prime", (n * int'(n_prime) + 1) % 256, 0);
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
